// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: a FETCH/DECODE/EXEC/MEM/WB sequencer,
// a retired-instruction counter and a sticky illegal-instruction flag.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        J_type,
    output logic        Branch,
    output logic        PCsrc,
    output logic        RegWrite,
    output logic        ALUsrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  ALUop,
    output logic [1:0]  RegDest,
    output logic [1:0]  WriteReg,
    output logic        err,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_SLT, K_JR, K_ADDI, K_SLTI,
        K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD
    } kind_t;

    // X or unknown encodings never match a case item, so they land on K_BAD.
    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        kind_t k;
        k = K_BAD;
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000: k = K_ADD;
                    6'b100010: k = K_SUB;
                    6'b101010: k = K_SLT;
                    6'b001000: k = K_JR;
                    default:   k = K_BAD;
                endcase
            end
            6'b001000: k = K_ADDI;
            6'b001010: k = K_SLTI;
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000010: k = K_J;
            6'b000011: k = K_JAL;
            default:   k = K_BAD;
        endcase
        return k;
    endfunction

    state_t      state;
    logic [5:0]  op_q;
    logic [5:0]  func_q;
    logic [15:0] count_q;
    logic        err_q;
    kind_t       dec_kind;
    kind_t       kind;

    assign dec_kind    = classify(op, func);
    assign kind        = classify(op_q, func_q);
    assign instr_count = count_q;
    assign err         = err_q & ~rst;

    // Sequencer, opcode capture, retire counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            op_q    <= 6'd0;
            func_q  <= 6'd0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            if (pc_write)
                count_q <= count_q + 16'd1;
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    op_q   <= op;
                    func_q <= func;
                    if (dec_kind == K_BAD) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (kind)
                        K_LW, K_SW:                state <= MEM;
                        K_BEQ, K_J, K_JAL, K_JR:   state <= FETCH;
                        K_BAD:                     state <= ERR;
                        default:                   state <= WB;
                    endcase
                end
                MEM:     state <= (kind == K_LW) ? WB : FETCH;
                WB:      state <= FETCH;
                ERR:     state <= ERR;
                default: state <= FETCH;
            endcase
        end
    end

    // Control outputs decode from state and the captured instruction; while
    // rst is high everything is held low so an aborted instruction never retires.
    always_comb begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        J_type   = 1'b0;
        Branch   = 1'b0;
        PCsrc    = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUop    = 3'b000;
        RegDest  = 2'b00;
        WriteReg = 2'b00;
        if (!rst) begin
            case (state)
                FETCH: ir_write = 1'b1;
                EXEC: begin
                    case (kind)
                        K_ADD:  ALUop = 3'b000;
                        K_SUB:  ALUop = 3'b001;
                        K_SLT:  ALUop = 3'b001;
                        K_ADDI: ALUsrc = 1'b1;
                        K_SLTI: begin
                            ALUsrc = 1'b1;
                            ALUop  = 3'b001;
                        end
                        K_LW, K_SW: ALUsrc = 1'b1;
                        K_BEQ: begin
                            ALUop    = 3'b001;
                            Branch   = 1'b1;
                            PCsrc    = zero;
                            pc_write = 1'b1;
                        end
                        K_J: begin
                            PCsrc    = 1'b1;
                            pc_write = 1'b1;
                        end
                        K_JAL: begin
                            PCsrc    = 1'b1;
                            pc_write = 1'b1;
                            RegWrite = 1'b1;
                            RegDest  = 2'b10;
                            WriteReg = 2'b11;
                        end
                        K_JR: begin
                            J_type   = 1'b1;
                            PCsrc    = 1'b1;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (kind == K_LW) begin
                        MemRead = 1'b1;
                    end else if (kind == K_SW) begin
                        MemWrite = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                WB: begin
                    RegWrite = 1'b1;
                    pc_write = 1'b1;
                    case (kind)
                        K_ADD, K_SUB: begin
                            RegDest  = 2'b01;
                            WriteReg = 2'b00;
                        end
                        K_SLT: begin
                            RegDest  = 2'b01;
                            WriteReg = 2'b01;
                        end
                        K_SLTI: WriteReg = 2'b01;
                        K_LW:   WriteReg = 2'b10;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl; expectations come from
// a cycle-indexed per-instruction model of the control signals.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        zero = 1'b0;
    logic        pc_write, ir_write, J_type, Branch, PCsrc, RegWrite;
    logic        ALUsrc, MemRead, MemWrite, err;
    logic [2:0]  ALUop;
    logic [1:0]  RegDest, WriteReg;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_count = 16'd0;

    typedef struct packed {
        logic       pc_write, ir_write, J_type, Branch, PCsrc;
        logic       RegWrite, ALUsrc, MemRead, MemWrite;
        logic [2:0] ALUop;
        logic [1:0] RegDest, WriteReg;
        logic       err;
    } ctl_t;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .J_type(J_type),
        .Branch(Branch), .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUop(ALUop),
        .RegDest(RegDest), .WriteReg(WriteReg), .err(err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic ctl_t observed();
        ctl_t a;
        a = '{pc_write, ir_write, J_type, Branch, PCsrc, RegWrite, ALUsrc,
              MemRead, MemWrite, ALUop, RegDest, WriteReg, err};
        return a;
    endfunction

    function automatic int instr_len(input string m);
        case (m)
            "lw":                    return 5;
            "beq", "j", "jal", "jr": return 3;
            default:                 return 4;
        endcase
    endfunction

    function automatic void encode(input string m, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (m)
            "add":  begin o = 6'b000000; f = 6'b100000; end
            "sub":  begin o = 6'b000000; f = 6'b100010; end
            "slt":  begin o = 6'b000000; f = 6'b101010; end
            "jr":   begin o = 6'b000000; f = 6'b001000; end
            "addi": o = 6'b001000;
            "slti": o = 6'b001010;
            "lw":   o = 6'b100011;
            "sw":   o = 6'b101011;
            "beq":  o = 6'b000100;
            "j":    o = 6'b000010;
            default: o = 6'b000011;
        endcase
    endfunction

    // Expected controls for cycle c of instruction m (0 = fetch, 1 = decode).
    function automatic ctl_t model(input string m, input int c, input logic z);
        ctl_t e;
        int last;
        e = '0;
        last = instr_len(m) - 1;
        if (c == 0) e.ir_write = 1'b1;
        if (c == last) e.pc_write = 1'b1;
        if (c == 2) begin
            case (m)
                "sub", "slt": e.ALUop = 3'b001;
                "addi", "lw", "sw": e.ALUsrc = 1'b1;
                "slti": begin e.ALUsrc = 1'b1; e.ALUop = 3'b001; end
                "beq":  begin e.ALUop = 3'b001; e.Branch = 1'b1; e.PCsrc = z; end
                "j":    e.PCsrc = 1'b1;
                "jal":  begin e.PCsrc = 1'b1; e.RegWrite = 1'b1; e.RegDest = 2'b10; e.WriteReg = 2'b11; end
                "jr":   begin e.J_type = 1'b1; e.PCsrc = 1'b1; end
                default: ;
            endcase
        end
        if (c == 3 && m == "lw") e.MemRead = 1'b1;
        if (c == 3 && m == "sw") e.MemWrite = 1'b1;
        if (c == last && c >= 3 && m != "sw") begin
            e.RegWrite = 1'b1;
            case (m)
                "add", "sub": e.RegDest = 2'b01;
                "slt":  begin e.RegDest = 2'b01; e.WriteReg = 2'b01; end
                "slti": e.WriteReg = 2'b01;
                "lw":   e.WriteReg = 2'b10;
                default: ;
            endcase
        end
        return e;
    endfunction

    // zmode: 0/1 drive zero constant, 2 randomize it every cycle; cycles
    // beyond stop_at are not run (stop_at < 0 runs the whole instruction).
    task automatic run_instr(input string m, input int zmode, input int stop_at);
        logic [5:0] o, f;
        ctl_t e, a;
        int n;
        encode(m, o, f);
        n = (stop_at >= 0) ? stop_at : instr_len(m);
        for (int c = 0; c < n; c++) begin
            op   = (c == 1) ? o : 6'($urandom);
            func = (c == 1) ? f : 6'($urandom);
            zero = (zmode == 2) ? 1'($urandom) : zmode[0];
            #1;
            e = model(m, c, zero);
            a = observed();
            checks++;
            if (a !== e) begin
                errors++;
                $display("[TB] FAIL %s_c%0d ctl got %h expected %h", m, c, a, e);
            end
            checks++;
            if (instr_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL %s_c%0d count got %h expected %h", m, c, instr_count, exp_count);
            end
            @(negedge clk);
        end
        if (stop_at < 0) exp_count = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        ctl_t e;
        rst = 1'b1;
        op  = 6'($urandom);
        #1;
        checks++;
        if (observed() !== ctl_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_cycle ctl got %h expected 0", observed());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        e = '0;
        e.ir_write = 1'b1;
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("[TB] FAIL post_reset ctl got %h expected %h", observed(), e);
        end
        checks++;
        if (instr_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL post_reset count got %h expected 0", instr_count);
        end
        exp_count = 16'd0;
    endtask

    task automatic test_add();
        run_instr("add", 2, -1);
    endtask

    task automatic test_lw_sw();
        run_instr("lw", 2, -1);
        run_instr("sw", 2, -1);
    endtask

    task automatic test_beq();
        run_instr("beq", 1, -1);
        run_instr("beq", 0, -1);
    endtask

    task automatic test_jal_jr();
        run_instr("jal", 2, -1);
        run_instr("jr", 2, -1);
    endtask

    task automatic test_illegal();
        ctl_t e;
        for (int c = 0; c < 12; c++) begin
            op   = (c == 1) ? 6'b111111 : 6'($urandom);
            func = 6'($urandom);
            zero = 1'($urandom);
            #1;
            e = '0;
            if (c == 0) e.ir_write = 1'b1;
            if (c >= 2) e.err = 1'b1;
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("[TB] FAIL illegal_c%0d ctl got %h expected %h", c, observed(), e);
            end
            checks++;
            if (instr_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL illegal_c%0d count got %h expected %h", c, instr_count, exp_count);
            end
            @(negedge clk);
        end
        test_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_clear err got %b expected 0", err);
        end
    endtask

    task automatic test_wrap();
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFF;
        run_instr("j", 2, -1);
        #1;
        checks++;
        if (instr_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap count got %h expected 0000", instr_count);
        end
    endtask

    task automatic test_reset_mid_lw();
        run_instr("add", 2, -1);
        run_instr("lw", 2, 3);
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== ctl_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_in_mem ctl got %h expected 0", observed());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ir_write !== 1'b1 || instr_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL after_mid_reset ir_write %b count %h expected 1 and 0000", ir_write, instr_count);
        end
        exp_count = 16'd0;
        run_instr("sw", 2, -1);
    endtask

    task automatic test_random();
        string names[11] = '{"add", "sub", "slt", "jr", "addi", "slti",
                             "lw", "sw", "beq", "j", "jal"};
        for (int i = 0; i < 60; i++)
            run_instr(names[$urandom_range(0, 10)], 2, -1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_sw();
        test_beq();
        test_jal_jr();
        test_random();
        test_illegal();
        test_reset_mid_lw();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have port op, input, width 6: opcode from the datapath, valid from DECODE onward.
REQ-003 The block SHALL have port func, input, width 6: R-type function field, valid from DECODE onward.
REQ-004 The block SHALL have port zero, input, width 1: ALU zero flag.
REQ-005 The block SHALL have single-bit outputs pc_write, ir_write, J_type, Branch, PCsrc, RegWrite, ALUsrc, MemRead and MemWrite, each with the datapath control meaning.
REQ-006 The block SHALL have the following multi-bit outputs:
- ALUop, output, width 3: 000 add, 001 sub.
- RegDest, output, width 2: 00 rt, 01 rd, 10 $31.
- WriteReg, output, width 2: 00 ALU, 01 slt bit, 10 mem, 11 pc+4.
REQ-007 The block SHALL have port err, output, width 1: sticky illegal-instruction flag.
REQ-008 The block SHALL have port instr_count, output, width 16: count of retired instructions.

Function
REQ-009 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and ERR=7, held in a 3-bit state register.
REQ-010 In FETCH the block SHALL drive ir_write=1, with all other enables at 0; the next state is DECODE.
REQ-011 In DECODE the block SHALL register op and func into op_q and func_q, and SHALL go to ERR if the opcode/func pair is unsupported, otherwise to EXEC.
REQ-012 The supported instructions SHALL be:
- R-type (op 000000) with add 100000, sub 100010, slt 101010, jr 001000.
- addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-013 For add and sub, EXEC SHALL drive ALUsrc=0, with ALUop=000 or 001 respectively; WB SHALL drive RegWrite=1, RegDest=01, WriteReg=00 and pc_write=1.
REQ-014 For slt, EXEC SHALL drive ALUop=001; WB SHALL drive RegWrite=1, RegDest=01, WriteReg=01 and pc_write=1.
REQ-015 For addi and slti, EXEC SHALL drive ALUsrc=1, with ALUop 000 for addi or 001 for slti; WB SHALL drive RegDest=00, with WriteReg 00 for addi or 01 for slti, plus RegWrite=1 and pc_write=1.
REQ-016 For lw, EXEC SHALL drive ALUsrc=1 and ALUop=000; MEM SHALL drive MemRead=1; WB SHALL drive RegWrite=1, RegDest=00, WriteReg=10 and pc_write=1. The sequence is 5 cycles.
REQ-017 For sw, EXEC SHALL drive ALUsrc=1 and ALUop=000; MEM SHALL drive MemWrite=1 and pc_write=1, and the next state is FETCH. The sequence is 4 cycles.
REQ-018 For beq, EXEC SHALL drive ALUop=001, Branch=1, PCsrc=zero and pc_write=1; the next state is FETCH. The sequence is 3 cycles.
REQ-019 For j, EXEC SHALL drive J_type=0, Branch=0, PCsrc=1 and pc_write=1.
REQ-020 For jal, EXEC SHALL drive the same signals as j plus RegWrite=1, RegDest=10 and WriteReg=11.
REQ-021 For jr, EXEC SHALL drive J_type=1, PCsrc=1 and pc_write=1. The j, jal and jr sequences are 3 cycles each.
REQ-022 All outputs not listed for a state SHALL be 0, with zero used combinationally only for PCsrc in beq EXEC.
REQ-023 pc_write SHALL be asserted in exactly one cycle per instruction, namely its final state; the next state after that cycle is FETCH.
REQ-024 instr_count SHALL increment by 1 on each clock edge where pc_write=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 In ERR the block SHALL drive err=1 with all enables at 0, and SHALL remain in ERR until rst; instr_count is held.
REQ-026 The block SHALL not emit X: undefined op or func values in DECODE SHALL be treated as unsupported.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=FETCH, op_q=0, func_q=0, instr_count=0 and err=0.
REQ-028 During the reset cycle, all outputs SHALL evaluate as in FETCH with ir_write forced to 0.
REQ-029 A rst asserted in any state, including mid-instruction or in ERR, SHALL abort the instruction with no pc_write, and the next cycle after reset deasserts SHALL be FETCH.

Verification
REQ-030 Scenario add: op=000000, func=100000 -> states 0,1,2,4 over 4 cycles; WB has RegWrite=1, RegDest=01, WriteReg=00 and pc_write=1; instr_count goes 0 to 1.
REQ-031 Scenario lw then sw: op=100011 -> 5 cycles with MemRead=1 only in MEM; then op=101011 -> 4 cycles with MemWrite=1 and pc_write=1 in MEM; instr_count=2.
REQ-032 Scenario beq: op=000100 with zero=1 -> EXEC has Branch=1, PCsrc=1 and pc_write=1; with zero=0 -> PCsrc=0; each case takes 3 cycles.
REQ-033 Scenario jal and jr: op=000011 -> EXEC has RegDest=10, WriteReg=11, RegWrite=1 and PCsrc=1; op=000000 with func=001000 -> EXEC has J_type=1.
REQ-034 Scenario illegal instruction and wrap: op=111111 -> ERR is entered at cycle 3, err=1 stays set for 10 cycles, and rst returns the block to FETCH with err=0. After preloading 65535 retired instructions, one more gives instr_count=0x0000.
REQ-035 Scenario reset mid-lw: rst asserted in MEM -> no RegWrite is issued, and the next cycle is FETCH with instr_count=0.
